// File: rtl/yacht_pkg.sv
// Shared definitions for the Yacht Dice score evaluator: category indices,
// fixed category scores, FSM encoding and the die-face type.
package yacht_pkg;

    localparam int NUM_CAT         = 12;
    localparam int CAT_ACES        = 0;
    localparam int CAT_TWOS        = 1;
    localparam int CAT_THREES      = 2;
    localparam int CAT_FOURS       = 3;
    localparam int CAT_FIVES       = 4;
    localparam int CAT_SIXES       = 5;
    localparam int CAT_CHOICE      = 6;
    localparam int CAT_FOUR_KIND   = 7;
    localparam int CAT_FULL_HOUSE  = 8;
    localparam int CAT_S_STRAIGHT  = 9;
    localparam int CAT_L_STRAIGHT  = 10;
    localparam int CAT_YACHT       = 11;

    localparam int SCORE_SSTRAIGHT = 15;
    localparam int SCORE_LSTRAIGHT = 30;
    localparam int SCORE_YACHT     = 50;

    typedef logic [2:0] face_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_EVAL,
        ST_SCAN,
        ST_DONE
    } state_t;

    function automatic logic face_legal(input face_t f);
        return (f != 3'd0) && (f != 3'd7);
    endfunction

endpackage

// File: rtl/yacht_score_evaluator_if.sv
// Request/result bundle between the game FSM (master) and the score evaluator (slave).
interface yacht_score_evaluator_if #(
    parameter int SCORE_W = 6,
    parameter int CAT_W   = 4
);
    import yacht_pkg::*;

    logic               calc_start;
    face_t              dice1, dice2, dice3, dice4, dice5;
    logic [CAT_W-1:0]   cat_sel;
    logic               busy;
    logic               score_valid;
    logic [SCORE_W-1:0] score;
    logic               dice_err;
    logic [CAT_W-1:0]   best_cat;
    logic [SCORE_W-1:0] best_score;

    modport master (
        output calc_start, dice1, dice2, dice3, dice4, dice5, cat_sel,
        input  busy, score_valid, score, dice_err, best_cat, best_score
    );

    modport slave (
        input  calc_start, dice1, dice2, dice3, dice4, dice5, cat_sel,
        output busy, score_valid, score, dice_err, best_cat, best_score
    );

endinterface

// File: rtl/yacht_score_evaluator_dice_histogram.sv
// Serial face histogram: one die per enabled cycle feeds per-face counters,
// a running face sum and a sticky illegal-face flag.
module dice_histogram
    import yacht_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            en,
    input  face_t           face,
    output logic [6:1][2:0] cnt,
    output logic [4:0]      sum,
    output logic            err
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            sum <= '0;
            err <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
            sum <= '0;
            err <= 1'b0;
        end else if (en) begin
            if (face_legal(face)) begin
                for (int f = 1; f <= 6; f++) begin
                    if (face == 3'(f)) cnt[f] <= cnt[f] + 3'd1;
                end
                sum <= sum + 5'(face);
            end else begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/yacht_score_evaluator.sv
// Yacht Dice score evaluator: latch dice, histogram them, score all categories.
// Optional best-category scan is built when CATEGORY_BEST_EN is defined.
module yacht_score_evaluator
    import yacht_pkg::*;
#(
    parameter int SCORE_W = 6,
    parameter int CAT_W   = 4
) (
    input logic                     clk,
    input logic                     reset,
    yacht_score_evaluator_if.slave  bus
);

    state_t           state;
    face_t            die_q [5];
    logic [CAT_W-1:0] cat_sel_q;
    logic [2:0]       die_idx;

    logic [6:1][2:0]  hist_cnt;
    logic [4:0]       hist_sum;
    logic             hist_err;

    logic [SCORE_W-1:0] eval_score [NUM_CAT];
    logic [SCORE_W-1:0] cat_score  [NUM_CAT];

    logic [6:1] present;
    logic       any4, any5, has3, has2;

`ifdef CATEGORY_BEST_EN
    logic [3:0]         scan_idx;
    logic [SCORE_W-1:0] run_max;
    logic [CAT_W-1:0]   run_cat;
`endif

    dice_histogram u_hist (
        .clk   (clk),
        .reset (reset),
        .clear (state == ST_IDLE && bus.calc_start),
        .en    (state == ST_COUNT),
        .face  (die_q[die_idx]),
        .cnt   (hist_cnt),
        .sum   (hist_sum),
        .err   (hist_err)
    );

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        any4 = 1'b0;
        any5 = 1'b0;
        has3 = 1'b0;
        has2 = 1'b0;
        for (int f = 1; f <= 6; f++) begin
            present[f] = (hist_cnt[f] != 3'd0);
            if (hist_cnt[f] >= 3'd4) any4 = 1'b1;
            if (hist_cnt[f] == 3'd5) any5 = 1'b1;
            if (hist_cnt[f] == 3'd3) has3 = 1'b1;
            if (hist_cnt[f] == 3'd2) has2 = 1'b1;
        end
        for (int c = 0; c < NUM_CAT; c++) eval_score[c] = '0;
        if (!hist_err) begin
            for (int f = 1; f <= 6; f++) eval_score[f-1] = SCORE_W'(f * int'(hist_cnt[f]));
            eval_score[CAT_CHOICE]     = SCORE_W'(hist_sum);
            eval_score[CAT_FOUR_KIND]  = any4 ? SCORE_W'(hist_sum) : '0;
            // Five dice total, so a 3-count plus a 2-count is always two distinct faces.
            eval_score[CAT_FULL_HOUSE] = (has3 && has2) ? SCORE_W'(hist_sum) : '0;
            eval_score[CAT_S_STRAIGHT] = (&present[4:1] || &present[5:2] || &present[6:3])
                                         ? SCORE_W'(SCORE_SSTRAIGHT) : '0;
            eval_score[CAT_L_STRAIGHT] = (&present[5:1] || &present[6:2])
                                         ? SCORE_W'(SCORE_LSTRAIGHT) : '0;
            eval_score[CAT_YACHT]      = any5 ? SCORE_W'(SCORE_YACHT) : '0;
        end
    end

    // NOTE: the score table is not reset; EVAL always rewrites it before SCAN or DONE reads it.
    always_ff @(posedge clk) begin
        if (state == ST_EVAL) begin
            for (int c = 0; c < NUM_CAT; c++) cat_score[c] <= eval_score[c];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            for (int i = 0; i < 5; i++) die_q[i] <= '0;
            cat_sel_q       <= '0;
            die_idx         <= '0;
            bus.busy        <= 1'b0;
            bus.score_valid <= 1'b0;
            bus.score       <= '0;
            bus.dice_err    <= 1'b0;
`ifdef CATEGORY_BEST_EN
            scan_idx        <= '0;
            run_max         <= '0;
            run_cat         <= '0;
            bus.best_cat    <= '0;
            bus.best_score  <= '0;
`endif
        end else begin
            bus.score_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.calc_start) begin
                        die_q[0]  <= bus.dice1;
                        die_q[1]  <= bus.dice2;
                        die_q[2]  <= bus.dice3;
                        die_q[3]  <= bus.dice4;
                        die_q[4]  <= bus.dice5;
                        cat_sel_q <= bus.cat_sel;
                        die_idx   <= '0;
                        bus.busy  <= 1'b1;
                        state     <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (die_idx == 3'd4) state <= ST_EVAL;
                    else                 die_idx <= die_idx + 3'd1;
                end
                ST_EVAL: begin
`ifdef CATEGORY_BEST_EN
                    scan_idx <= '0;
                    run_max  <= '0;
                    run_cat  <= '0;
                    state    <= ST_SCAN;
`else
                    state    <= ST_DONE;
`endif
                end
`ifdef CATEGORY_BEST_EN
                ST_SCAN: begin
                    // Strictly greater keeps the lowest index on ties.
                    if (cat_score[scan_idx] > run_max) begin
                        run_max <= cat_score[scan_idx];
                        run_cat <= CAT_W'(scan_idx);
                    end
                    if (scan_idx == 4'(NUM_CAT - 1)) state <= ST_DONE;
                    else                             scan_idx <= scan_idx + 4'd1;
                end
`endif
                ST_DONE: begin
                    bus.score       <= (cat_sel_q < CAT_W'(NUM_CAT)) ? cat_score[cat_sel_q] : '0;
                    bus.dice_err    <= hist_err;
                    bus.score_valid <= 1'b1;
                    bus.busy        <= 1'b0;
                    state           <= ST_IDLE;
`ifdef CATEGORY_BEST_EN
                    bus.best_cat    <= run_cat;
                    bus.best_score  <= run_max;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef CATEGORY_BEST_EN
    assign bus.best_cat   = '0;
    assign bus.best_score = '0;
`endif

endmodule
